// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit and its neighbours:
// bus widths, FSM state encoding, RW codes and the address range check.
package data_mem_access_unit_pkg;

    localparam int WORD_W     = 32;
    localparam int BUS_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Full-width compare against the RAM depth; addresses never wrap.
    function automatic logic addr_in_range(input logic [BUS_ADDR_W-1:0] addr,
                                           input int depth);
        return ({16'd0, addr} < $unsigned(depth));
    endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Request/response bus between the memory-control stage and the access unit.
interface data_mem_access_unit_if;
    import data_mem_access_unit_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [BUS_ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  ldr_load;
    logic                  busy;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ldr_load, busy
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ldr_load, busy
    );

endinterface

// File: rtl/data_mem_access_unit_dmem_array.sv
// Single-port synchronous data RAM. Contents are never reset; the read
// register only changes on an enabled read so it holds between accesses.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // One access per enable: write the array or capture read data.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_access_unit.sv
// Data-memory access unit: accepts one load/store, waits WAIT_STATES cycles,
// performs the RAM access and holds the response until it is consumed.
//
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | counting wait states; access happens when the counter is 0
//   RESP  | response valid, waiting for rsp_ready
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    data_mem_access_unit_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [BUS_ADDR_W-1:0] r_addr;
    logic                  r_rw;
    logic [WORD_W-1:0]     r_wdata;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_busy;
    logic                  r_rsp_err;
    logic                  r_rd_ok;

    logic                  w_access;
    logic                  w_in_range;
    logic                  w_ram_en;
    logic                  w_ram_we;
    logic [WORD_W-1:0]     w_ram_rdata;

    assign w_access   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    assign w_in_range = addr_in_range(r_addr, DEPTH);
    assign w_ram_en   = w_access & w_in_range;
    assign w_ram_we   = w_ram_en & (r_rw == RW_WRITE);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[AW-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Sequencer: request latch, wait-state down-counter and response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_rw        <= RW_READ;
            r_wdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_ok     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_rw        <= bus.req_rw;
                        r_wdata     <= bus.req_wdata;
                        r_cnt       <= 4'(WAIT_STATES);
                        r_state     <= ST_BUSY;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ~w_in_range;
                        r_rd_ok     <= w_in_range & (r_rw == RW_READ);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Read data lives in the RAM output register; it is only exposed for a
    // successful read, so writes and errored accesses show zero.
    assign bus.rsp_rdata = r_rd_ok ? w_ram_rdata : '0;
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;
    assign bus.ldr_load  = r_rsp_valid & bus.rsp_ready & (r_rw == RW_READ) & ~r_rsp_err;

endmodule
